// File: rtl/vga_mainmenu_controller.sv
// Main-menu input controller: debounced buttons -> option grid navigation + start pulse.
// Optional AUTOREPEAT_EN macro enables held-direction auto-repeat.
module vga_mainmenu_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        menu_return,
  output logic [2:0]  menu_sel,
  output logic [28:0] metadata,
  output logic        menu_active,
  output logic        start_pulse,
  output logic [2:0]  start_mode
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  sel_q;
  logic [2:0]  sel_d;
  logic        active_q;
  logic        pulse_q;
  logic [2:0]  mode_q;

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 select
  logic [4:0]    raw;
  logic [4:0]    sync1_q;
  logic [4:0]    sync2_q;
  logic [4:0]    stab_q;
  logic [4:0]    stab_d;
  logic [4:0]    prev_q;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [4:0]    press;
  logic [4:0]    ev;

  assign raw = {btn_select, btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i]  = cnt_q[i];
      stab_d[i] = stab_q[i];
      if (sync2_q[i] == stab_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        stab_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stab_q  <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stab_q  <= stab_d;
      prev_q  <= stab_q;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press = stab_q & ~prev_q;

`ifdef AUTOREPEAT_EN
  localparam logic [31:0] RDLY = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPER = 32'(REPEAT_PERIOD - 1);

  logic [31:0] rpt_cnt_q;
  logic        rpt_first_q;
  logic        restart;
  logic        rpt_fire;
  logic [3:0]  held;

  assign held    = stab_q[3:0];
  assign restart = (|press) | (|(prev_q & ~stab_q));
  assign rpt_fire = !restart && (|held) && (state_q == MENU) &&
                    (rpt_first_q ? (rpt_cnt_q == RDLY)
                                 : (rpt_cnt_q == RPER));

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (restart || !(|held) || state_q != MENU) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + 32'd1;
    end
  end

  assign ev = press | {1'b0, held & {4{rpt_fire}}};
`else
  assign ev = press;
`endif

  // priority: up > down > left > right; select handled by the FSM
  always_comb begin
    sel_d = sel_q;
    if (ev[0]) begin
      case (sel_q)
        3'd1:    sel_d = 3'd0;
        3'd2:    sel_d = 3'd1;
        3'd4:    sel_d = 3'd3;
        default: sel_d = sel_q;
      endcase
    end else if (ev[1]) begin
      case (sel_q)
        3'd0:    sel_d = 3'd1;
        3'd1:    sel_d = 3'd2;
        3'd3:    sel_d = 3'd4;
        default: sel_d = sel_q;
      endcase
    end else if (ev[2]) begin
      case (sel_q)
        3'd3:    sel_d = 3'd0;
        3'd4:    sel_d = 3'd1;
        default: sel_d = sel_q;
      endcase
    end else if (ev[3]) begin
      case (sel_q)
        3'd0:    sel_d = 3'd3;
        3'd1:    sel_d = 3'd4;
        3'd2:    sel_d = 3'd4;
        default: sel_d = sel_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MENU;
      sel_q    <= 3'd0;
      active_q <= 1'b1;
      pulse_q  <= 1'b0;
      mode_q   <= 3'd0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        MENU: begin
          if (ev[4]) begin
            state_q  <= CONFIRM;
            pulse_q  <= 1'b1;
            mode_q   <= sel_q;
            active_q <= 1'b0;
          end else begin
            sel_q <= sel_d;
          end
        end
        CONFIRM: begin
          state_q <= LOCKED;
        end
        LOCKED: begin
          if (menu_return) begin
            state_q  <= MENU;
            active_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= MENU;
          active_q <= 1'b1;
        end
      endcase
    end
  end

  assign menu_sel    = sel_q;
  assign metadata    = {sel_q, 26'd0};
  assign menu_active = active_q;
  assign start_pulse = pulse_q;
  assign start_mode  = mode_q;

endmodule
